// File: rtl/tdm_mux_param.sv
// Parametrised TDM multiplexer: per-channel FIFOs drained one word per slot into a single
// tagged output stream, with either fixed round-robin slots or skip-empty arbitration.
module tdm_mux_param #(
    parameter int  CHANNELS   = 4,
    parameter int  WIDTH      = 4,
    parameter int  DEPTH      = 8,
    parameter int  SKIP_EMPTY = 0,
    localparam int SELW       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       wr,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [CHANNELS-1:0]       full,
    output logic [CHANNELS-1:0]       empty,
    output logic [CHANNELS-1:0]       overflow,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      frame_start
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [CHANNELS][DEPTH];
    logic [AW-1:0]    r_wrPtr [CHANNELS];
    logic [AW-1:0]    r_rdPtr [CHANNELS];
    logic [AW:0]      r_count [CHANNELS];
    logic [SELW-1:0]  r_ptr;
    logic [SELW-1:0]  r_lastGrant;
    logic             r_hadGrant;

    logic [SELW-1:0]     w_grant;
    logic                w_grantValid;
    logic [CHANNELS-1:0] w_pop;
    logic [CHANNELS-1:0] w_accept;
    logic [AW:0]         w_nextCount [CHANNELS];
    logic [WIDTH-1:0]    w_popData;

    // Channel index arithmetic wraps at CHANNELS, which need not be a power of two.
    function automatic logic [SELW-1:0] wrapInc(input logic [SELW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= CHANNELS) sum = sum - CHANNELS;
        return SELW'(sum);
    endfunction

    // Skip mode scans from the highest offset down so the nearest non-empty channel wins.
    always_comb begin
        w_grant      = r_ptr;
        w_grantValid = 1'b0;
        if (SKIP_EMPTY == 0) begin
            w_grantValid = en && !empty[r_ptr];
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (en && !empty[wrapInc(r_ptr, i)]) begin
                    w_grant      = wrapInc(r_ptr, i);
                    w_grantValid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_pop[ch]       = w_grantValid && (w_grant == SELW'(ch));
            w_accept[ch]    = wr[ch] && (!full[ch] || w_pop[ch]);
            w_nextCount[ch] = r_count[ch] + (AW+1)'(w_accept[ch]) - (AW+1)'(w_pop[ch]);
        end
    end

    assign w_popData = r_mem[w_grant][r_rdPtr[w_grant]];

    // Storage carries no reset; the pointers alone define which words are live.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (w_accept[ch]) r_mem[ch][r_wrPtr[ch]] <= din[ch*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_wrPtr[ch] <= '0;
                r_rdPtr[ch] <= '0;
                r_count[ch] <= '0;
            end
            full     <= '0;
            empty    <= '1;
            overflow <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (w_accept[ch]) r_wrPtr[ch] <= r_wrPtr[ch] + 1'b1;
                if (w_pop[ch])    r_rdPtr[ch] <= r_rdPtr[ch] + 1'b1;
                if (wr[ch] && !w_accept[ch]) overflow[ch] <= 1'b1;
                r_count[ch] <= w_nextCount[ch];
                full[ch]    <= (w_nextCount[ch] == FULL_COUNT);
                empty[ch]   <= (w_nextCount[ch] == '0);
            end
        end
    end

    // Frame boundary in skip mode: the grant wrapped around (or is the first since reset).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_lastGrant <= '0;
            r_hadGrant  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_chan    <= '0;
            frame_start <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            frame_start <= 1'b0;
            if (en) begin
                if (SKIP_EMPTY == 0) begin
                    out_chan    <= r_ptr;
                    out_valid   <= w_grantValid;
                    out_data    <= w_grantValid ? w_popData : '0;
                    frame_start <= (r_ptr == '0);
                    r_ptr       <= wrapInc(r_ptr, 1);
                end else if (w_grantValid) begin
                    out_chan    <= w_grant;
                    out_valid   <= 1'b1;
                    out_data    <= w_popData;
                    frame_start <= !r_hadGrant || (w_grant <= r_lastGrant);
                    r_lastGrant <= w_grant;
                    r_hadGrant  <= 1'b1;
                    r_ptr       <= wrapInc(w_grant, 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux_param.sv
// Bench for tdm_mux_param: a fixed-slot and a skip-empty instance side by side, each
// compared every cycle against a queue-based model of the multiplexer.
module tb_tdm_mux_param;

    localparam int CH = 4;
    localparam int W  = 4;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          en   [2];
    logic [CH-1:0] wr   [2];
    logic [CH*W-1:0] din [2];
    logic [CH-1:0] full [2];
    logic [CH-1:0] empty [2];
    logic [CH-1:0] ovf  [2];
    logic          oValid [2];
    logic [W-1:0]  oData  [2];
    logic [1:0]    oChan  [2];
    logic          oFs    [2];

    int checks = 0;
    int errors = 0;

    // Model: instance k, channel c lives in mq[k*CH+c].
    logic [W-1:0]  mq [2*CH][$];
    int            mp [2];
    int            mLast;
    bit            mHad;
    bit            expValid [2];
    logic [W-1:0]  expData  [2];
    int            expChan  [2];
    bit            expFs    [2];
    logic [CH-1:0] expOvf   [2];

    always #5 clk = ~clk;

    tdm_mux_param #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .SKIP_EMPTY(0)) u_fixed (
        .clk(clk), .reset(reset), .en(en[0]), .wr(wr[0]), .din(din[0]),
        .full(full[0]), .empty(empty[0]), .overflow(ovf[0]),
        .out_valid(oValid[0]), .out_data(oData[0]), .out_chan(oChan[0]), .frame_start(oFs[0])
    );

    tdm_mux_param #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .SKIP_EMPTY(1)) u_skip (
        .clk(clk), .reset(reset), .en(en[1]), .wr(wr[1]), .din(din[1]),
        .full(full[1]), .empty(empty[1]), .overflow(ovf[1]),
        .out_valid(oValid[1]), .out_data(oData[1]), .out_chan(oChan[1]), .frame_start(oFs[1])
    );

    function automatic logic [19:0] obsVec(input int k);
        return {oValid[k], oData[k], oChan[k], oFs[k], full[k], empty[k], ovf[k]};
    endfunction

    function automatic logic [19:0] expVec(input int k);
        logic [CH-1:0] f;
        logic [CH-1:0] e;
        for (int c = 0; c < CH; c++) begin
            f[c] = (mq[k*CH+c].size() == D);
            e[c] = (mq[k*CH+c].size() == 0);
        end
        return {expValid[k], expData[k], 2'(expChan[k]), expFs[k], f, e, expOvf[k]};
    endfunction

    task automatic modelReset();
        for (int q = 0; q < 2*CH; q++) mq[q].delete();
        for (int k = 0; k < 2; k++) begin
            mp[k] = 0; expValid[k] = 0; expData[k] = '0; expChan[k] = 0;
            expFs[k] = 0; expOvf[k] = '0;
        end
        mLast = 0;
        mHad  = 0;
    endtask

    task automatic modelClock();
        for (int k = 0; k < 2; k++) begin
            int g;
            g = -1;
            expValid[k] = 0;
            expData[k]  = '0;
            expFs[k]    = 0;
            if (en[k]) begin
                if (k == 0) begin
                    expChan[0] = mp[0];
                    expFs[0]   = (mp[0] == 0);
                    if (mq[mp[0]].size() > 0) begin
                        expValid[0] = 1;
                        expData[0]  = mq[mp[0]].pop_front();
                    end
                    mp[0] = (mp[0] + 1) % CH;
                end else begin
                    for (int i = 0; i < CH; i++)
                        if (g < 0 && mq[CH + (mp[1] + i) % CH].size() > 0) g = (mp[1] + i) % CH;
                    if (g >= 0) begin
                        expValid[1] = 1;
                        expData[1]  = mq[CH + g].pop_front();
                        expChan[1]  = g;
                        expFs[1]    = !mHad || (g <= mLast);
                        mLast       = g;
                        mHad        = 1;
                        mp[1]       = (g + 1) % CH;
                    end
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (wr[k][c]) begin
                    if (mq[k*CH+c].size() < D) mq[k*CH+c].push_back(din[k][c*W +: W]);
                    else expOvf[k][c] = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStep();
        @(posedge clk);
        modelClock();
        #1;
    endtask

    task automatic setIdle();
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0; wr[k] = '0; din[k] = '0;
        end
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            wr[0] = 4'b1111; din[0] = 16'($urandom);
            wr[1] = 4'b1111; din[1] = 16'($urandom);
            applyStep();
        end
        wr[0] = '0; wr[1] = '0; en[0] = 1'b1;
        applyStep();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsVec(k) !== expVec(k)) begin
                errors++;
                $display("FAIL reset_preload%0d: got %h expected %h", k, obsVec(k), expVec(k));
            end
        end
        reset = 1'b0;
        #2;
        modelReset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsVec(k) !== expVec(k)) begin
                errors++;
                $display("FAIL reset_vec%0d: got %h expected %h", k, obsVec(k), expVec(k));
            end
            checks++;
            if ({empty[k], oValid[k], ovf[k]} !== {4'b1111, 1'b0, 4'b0000}) begin
                errors++;
                $display("FAIL reset_flags%0d: got %b expected %b", k,
                         {empty[k], oValid[k], ovf[k]}, 9'b1111_0_0000);
            end
        end
        reset = 1'b1;
        setIdle();
    endtask

    task automatic test_fixed_rr();
        logic [W-1:0] pat [4];
        pat = '{4'h5, 4'h0, 4'h8, 4'hA};
        wr[0] = 4'b1111; din[0] = 16'hA805;
        applyStep();
        wr[0] = '0; en[0] = 1'b1;
        for (int s = 0; s < 4; s++) begin
            applyStep();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsVec(k) !== expVec(k)) begin
                    errors++;
                    $display("FAIL rr_vec%0d slot %0d: got %h expected %h", k, s, obsVec(k), expVec(k));
                end
            end
            checks++;
            if ({oValid[0], oData[0], oChan[0], oFs[0]} !== {1'b1, pat[s], 2'(s), s == 0}) begin
                errors++;
                $display("FAIL rr_slot%0d: got %b expected %b", s,
                         {oValid[0], oData[0], oChan[0], oFs[0]}, {1'b1, pat[s], 2'(s), s == 0});
            end
        end
        setIdle();
    endtask

    task automatic test_idle_slot();
        wr[0] = 4'b0100; din[0] = 16'h0B00;
        applyStep();
        wr[0] = '0; en[0] = 1'b1;
        for (int s = 0; s < 4; s++) begin
            applyStep();
            checks++;
            if (obsVec(0) !== expVec(0)) begin
                errors++;
                $display("FAIL idle_vec slot %0d: got %h expected %h", s, obsVec(0), expVec(0));
            end
            checks++;
            if ({oValid[0], oData[0], oChan[0]} !== {s == 2, (s == 2) ? 4'hB : 4'h0, 2'(s)}) begin
                errors++;
                $display("FAIL idle_slot%0d: got %b expected %b", s,
                         {oValid[0], oData[0], oChan[0]}, {s == 2, (s == 2) ? 4'hB : 4'h0, 2'(s)});
            end
        end
        setIdle();
    endtask

    task automatic test_overflow();
        int got;
        got = 0;
        for (int n = 0; n < 9; n++) begin
            wr[0] = 4'b0010; din[0] = 16'($urandom);
            applyStep();
            checks++;
            if (obsVec(0) !== expVec(0)) begin
                errors++;
                $display("FAIL ovf_fill write %0d: got %h expected %h", n, obsVec(0), expVec(0));
            end
        end
        checks++;
        if ({full[0][1], ovf[0][1]} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_flags: got %b expected 11", {full[0][1], ovf[0][1]});
        end
        wr[0] = '0; en[0] = 1'b1;
        for (int s = 0; s < 4*D; s++) begin
            applyStep();
            if (oValid[0] && oChan[0] == 2'd1) got++;
            checks++;
            if (obsVec(0) !== expVec(0)) begin
                errors++;
                $display("FAIL ovf_drain cycle %0d: got %h expected %h", s, obsVec(0), expVec(0));
            end
        end
        checks++;
        if (got != D) begin
            errors++;
            $display("FAIL ovf_words: got %0d expected %0d", got, D);
        end
        checks++;
        if ({empty[0][1], ovf[0][1]} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 11", {empty[0][1], ovf[0][1]});
        end
        setIdle();
    endtask

    task automatic test_skip();
        logic [7:0] want [6];
        // {valid, data, chan, fs}: ch1, ch3, idle, idle, then ch0 (wrap) and ch2
        want = '{8'b1_1111_01_1, 8'b1_1101_11_0, 8'b0_0000_11_0, 8'b0_0000_11_0,
                 8'b1_0110_00_1, 8'b1_1001_10_0};
        wr[1] = 4'b1010; din[1] = 16'hD0F0;
        applyStep();
        wr[1] = '0; en[1] = 1'b1;
        for (int s = 0; s < 6; s++) begin
            if (s == 3) begin
                wr[1] = 4'b0101; din[1] = 16'h0906;
            end else begin
                wr[1] = '0;
            end
            applyStep();
            checks++;
            if (obsVec(1) !== expVec(1)) begin
                errors++;
                $display("FAIL skip_vec step %0d: got %h expected %h", s, obsVec(1), expVec(1));
            end
            checks++;
            if ({oValid[1], oData[1], oChan[1], oFs[1]} !== want[s]) begin
                errors++;
                $display("FAIL skip_step%0d: got %b expected %b", s,
                         {oValid[1], oData[1], oChan[1], oFs[1]}, want[s]);
            end
        end
        setIdle();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < D; n++) begin
            wr[0] = 4'b0001; din[0] = 16'($urandom);
            applyStep();
        end
        en[0] = 1'b1;
        for (int s = 0; s < 4*D; s++) begin
            wr[0]  = (mp[0] == 0) ? 4'b0001 : 4'b0000;
            din[0] = 16'($urandom);
            applyStep();
            checks++;
            if (obsVec(0) !== expVec(0)) begin
                errors++;
                $display("FAIL b2b_vec cycle %0d: got %h expected %h", s, obsVec(0), expVec(0));
            end
            checks++;
            if ({full[0][0], ovf[0][0]} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_full cycle %0d: got %b expected 10", s, {full[0][0], ovf[0][0]});
            end
        end
        setIdle();
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            for (int k = 0; k < 2; k++) begin
                en[k]  = ($urandom_range(3) != 0);
                wr[k]  = 4'($urandom) & 4'($urandom);
                din[k] = 16'($urandom);
            end
            applyStep();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsVec(k) !== expVec(k)) begin
                    errors++;
                    $display("FAIL rand_vec%0d cycle %0d: got %h expected %h", k, s, obsVec(k), expVec(k));
                end
            end
        end
        setIdle();
    endtask

    initial begin
        reset = 1'b0;
        setIdle();
        modelReset();
        #12;
        reset = 1'b1;
        test_reset();
        test_fixed_rr();
        test_idle_slot();
        test_overflow();
        test_skip();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
